// File: rtl/user_obi_rr_arbiter.sv
// Round-robin OBI arbiter sharing one user-domain subordinate port between NumMgr managers.
// Decisions are held until granted; an in-order ID FIFO routes each response to its issuer.
module user_obi_rr_arbiter #(
  parameter int NumMgr    = 2,
  parameter int MaxTrans  = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumMgr-1:0]                mgr_req_i,
  output logic [NumMgr-1:0]                mgr_gnt_o,
  input  logic [NumMgr*AddrWidth-1:0]      mgr_addr_i,
  input  logic [NumMgr-1:0]                mgr_we_i,
  input  logic [NumMgr*(DataWidth/8)-1:0]  mgr_be_i,
  input  logic [NumMgr*DataWidth-1:0]      mgr_wdata_i,
  output logic [NumMgr-1:0]                mgr_rvalid_o,
  output logic [DataWidth-1:0]             mgr_rdata_o,
  output logic                             mgr_err_o,
  output logic                             sbr_req_o,
  output logic [AddrWidth-1:0]             sbr_addr_o,
  output logic                             sbr_we_o,
  output logic [DataWidth/8-1:0]           sbr_be_o,
  output logic [DataWidth-1:0]             sbr_wdata_o,
  input  logic                             sbr_gnt_i,
  input  logic                             sbr_rvalid_i,
  input  logic [DataWidth-1:0]             sbr_rdata_i,
  input  logic                             sbr_err_i,
  output logic                             busy_o,
  output logic                             proto_err_o,
  output logic                             dbg_locked_o
);

  localparam int IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
  localparam int PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int CntW = $clog2(MaxTrans) + 1;
  localparam int BeW  = DataWidth / 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e            lock_q;
  logic [IdxW-1:0]   rr_q;
  logic [IdxW-1:0]   sel_q;
  logic [IdxW-1:0]   fifo_q [MaxTrans];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   cnt_q;
  logic              proto_err_q;

  logic [IdxW-1:0]   scan_sel;
  logic [IdxW:0]     scan_sum;
  logic              scan_found;
  logic [IdxW-1:0]   sel;
  logic              sel_req;
  logic              full;
  logic              grant;
  logic              pop;
  logic              stray;
  logic [IdxW-1:0]   head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxTrans - 1)) ? '0 : p + 1'b1;
  endfunction

  // First requester at or above rr_q, wrapping modulo NumMgr.
  always_comb begin
    scan_sel   = rr_q;
    scan_sum   = '0;
    scan_found = 1'b0;
    for (int i = 0; i < NumMgr; i++) begin
      scan_sum = {1'b0, rr_q} + (IdxW+1)'(i);
      if (scan_sum >= (IdxW+1)'(NumMgr)) scan_sum = scan_sum - (IdxW+1)'(NumMgr);
      if (!scan_found && mgr_req_i[scan_sum[IdxW-1:0]]) begin
        scan_found = 1'b1;
        scan_sel   = scan_sum[IdxW-1:0];
      end
    end
  end

  assign sel       = (lock_q == ST_LOCKED) ? sel_q : scan_sel;
  assign sel_req   = mgr_req_i[sel];
  assign full      = (cnt_q == CntW'(MaxTrans));
  assign sbr_req_o = sel_req & ~full;
  assign grant     = sbr_req_o & sbr_gnt_i;
  assign head      = fifo_q[rd_ptr_q];
  assign pop       = sbr_rvalid_i & (cnt_q != '0);
  assign stray     = sbr_rvalid_i & (cnt_q == '0);

  always_comb begin
    mgr_gnt_o    = '0;
    mgr_rvalid_o = '0;
    sbr_addr_o   = '0;
    sbr_we_o     = 1'b0;
    sbr_be_o     = '0;
    sbr_wdata_o  = '0;
    for (int m = 0; m < NumMgr; m++) begin
      if (sel == IdxW'(m)) mgr_gnt_o[m] = grant;
      if (head == IdxW'(m)) mgr_rvalid_o[m] = pop;
      if (sel_req && (sel == IdxW'(m))) begin
        sbr_addr_o  = mgr_addr_i[m*AddrWidth +: AddrWidth];
        sbr_we_o    = mgr_we_i[m];
        sbr_be_o    = mgr_be_i[m*BeW +: BeW];
        sbr_wdata_o = mgr_wdata_i[m*DataWidth +: DataWidth];
      end
    end
  end

  assign mgr_rdata_o  = sbr_rdata_i;
  assign mgr_err_o    = sbr_err_i;
  assign busy_o       = (cnt_q != '0);
  assign proto_err_o  = proto_err_q;
  assign dbg_locked_o = (lock_q == ST_LOCKED);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q      <= ST_IDLE;
      rr_q        <= '0;
      sel_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
      for (int k = 0; k < MaxTrans; k++) fifo_q[k] <= '0;
    end else begin
      if (grant) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
        rr_q             <= (sel == IdxW'(NumMgr - 1)) ? '0 : sel + 1'b1;
        lock_q           <= ST_IDLE;
      end else if (lock_q == ST_IDLE) begin
        if (sbr_req_o) begin
          lock_q <= ST_LOCKED;
          sel_q  <= sel;
        end
      end else if (!sel_req) begin
        // Locked manager withdrew its request: release rather than wedge.
        lock_q <= ST_IDLE;
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({grant, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (stray) proto_err_q <= 1'b1;
    end
  end

endmodule

// File: doc/user_obi_rr_arbiter.md
# user_obi_rr_arbiter

Round-robin OBI arbiter that shares the single user-domain subordinate port (user ROM at 0x2000_0000, 4 KiB window; unmapped accesses go to the OBI error subordinate behind it) between `NumMgr` managers. It sits between the user-domain managers and the user-domain address demux. It holds each arbitration decision until the subordinate grants it, and tracks up to `MaxTrans` outstanding transactions in an in-order ID FIFO so every response returns to its issuing manager.

## Interface
- `NumMgr`, default 2: number of requesting managers, 2..8.
- `MaxTrans`, default 2: maximum outstanding granted-but-unanswered transactions, power of two, 1..8.
- `AddrWidth`, default 32; `DataWidth`, default 32: OBI address and data widths.

- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous and active-high.
- `mgr_req_i` in NumMgr: per-manager request.
- `mgr_gnt_o` out NumMgr: per-manager grant.
- `mgr_addr_i` in NumMgr×AddrWidth: request address.
- `mgr_we_i` in NumMgr: write enable.
- `mgr_be_i` in NumMgr×DataWidth/8: byte enables.
- `mgr_wdata_i` in NumMgr×DataWidth: write data.
- `mgr_rvalid_o` out NumMgr: per-manager response valid.
- `mgr_rdata_o` out DataWidth: response data, broadcast to all managers.
- `mgr_err_o` out 1: response error, broadcast to all managers.
- `sbr_req_o`, `sbr_addr_o`, `sbr_we_o`, `sbr_be_o`, `sbr_wdata_o` out: request toward the user demux.
- `sbr_gnt_i`, `sbr_rvalid_i`, `sbr_rdata_i`, `sbr_err_i` in: subordinate handshake and response.
- `busy_o` out 1: at least one transaction is outstanding.
- `proto_err_o` out 1: sticky flag; set by an `sbr_rvalid_i` that arrives with no transaction outstanding.

## Operation
- State:
  - Round-robin pointer `rr_q` (log2 NumMgr bits).
  - Lock register `lock_q` plus locked index `sel_q`.
  - ID FIFO of depth MaxTrans holding manager indices, with write/read pointers and a count `cnt_q` (log2 MaxTrans + 1 bits).
  - `proto_err_q`.
- Selection states:
  - IDLE (`lock_q`=0): the selected manager `sel` is the first requesting manager found scanning from `rr_q` upward, modulo NumMgr.
  - LOCKED (`lock_q`=1): `sel = sel_q` regardless of other requests. OBI requires a manager to hold `req` and its attributes until granted, so a decision is never changed before grant.
- Request path:
  - `sbr_req_o = mgr_req_i[sel] & ~full`, where `full = (cnt_q == MaxTrans)`.
  - Address, we, be and wdata are muxed from `sel`; they are 0 when no manager requests.
- Grant:
  - `mgr_gnt_o[sel] = sbr_gnt_i & sbr_req_o`; every other bit is 0.
  - On grant: push `sel` into the FIFO, set `rr_q <= sel+1` (mod NumMgr), and go to IDLE.
- Lock transitions:
  - IDLE -> LOCKED when `sbr_req_o` is asserted without `sbr_gnt_i`; `sel_q <= sel`.
  - LOCKED -> IDLE on grant.
  - If the locked manager drops `req` (a protocol violation), return to IDLE next cycle.
- Full: `sbr_req_o` is forced low and no grant is issued, even if a response pops the FIFO in the same cycle. There is no combinational path from `rvalid` to `gnt`.
- Response:
  - On `sbr_rvalid_i` with `cnt_q>0`: `mgr_rvalid_o[fifo_head]=1`, then pop.
  - `mgr_rdata_o = sbr_rdata_i` and `mgr_err_o = sbr_err_i`, passed through combinationally.
- Simultaneous push and pop: `cnt_q` is unchanged and both pointers advance. Pointers wrap modulo MaxTrans.
- Stray response: `sbr_rvalid_i` with `cnt_q==0` raises no `mgr_rvalid_o`, leaves the FIFO unchanged, and sets `proto_err_q`. It clears only on reset.
- `busy_o = (cnt_q != 0)`.

## Timing
- Reset: `rr_q`=0, `lock_q`=0, `sel_q`=0, FIFO empty (`cnt_q`=0, pointers 0), `proto_err_q`=0.
- Outputs after reset: `mgr_gnt_o`=0, `mgr_rvalid_o`=0, `sbr_req_o`=0, `busy_o`=0, `proto_err_o`=0.
- Reset mid-transaction drops all outstanding IDs. Responses arriving after reset are stray and set `proto_err_o`.
- Request path `mgr_req_i` -> `sbr_req_o` is zero-cycle combinational, as is `sbr_gnt_i` -> `mgr_gnt_o`.
- `sbr_rvalid_i` -> `mgr_rvalid_o` is zero-cycle combinational.
- A response may arrive at the earliest one cycle after its grant. A same-cycle response from an empty FIFO counts as stray.
- Throughput: one grant per cycle while not full. With a 1-cycle-latency subordinate and MaxTrans≥2 there are no bubbles.
- `rr_q`, `lock_q` and the FIFO update on the rising edge after the triggering handshake.

## Test plan
- **Single manager.** Manager 0 reads 0x2000_0004; subordinate grants immediately and responds next cycle with rdata 0xDEADBEEF. Required: `mgr_gnt_o`=01 in cycle 0, `mgr_rvalid_o`=01 with rdata 0xDEADBEEF in cycle 1, `busy_o` high only during cycle 1.
- **Round-robin fairness.** NumMgr=2, both managers request continuously; subordinate always grants and responds after 1 cycle. Required: grants alternate 0,1,0,1, and each response routes to the manager that issued it.
- **Lock hold.** Manager 1 requests; subordinate withholds `gnt` for 3 cycles; manager 0 starts requesting in cycle 1. Required: `sbr_addr_o` stays on manager 1 for all 4 cycles, manager 1 is granted in cycle 3, manager 0 is granted in cycle 4.
- **FIFO full.** MaxTrans=2, subordinate grants but delays responses 5 cycles. Required: exactly 2 grants, then `sbr_req_o`=0 until the first `rvalid`, and a new grant only in the cycle after that pop.
- **Error and stray response.** A response to a request at 0x2000_2000 carries `sbr_err_i`=1. Required: `mgr_err_o`=1 with `rvalid` routed to the issuing manager. Then an `sbr_rvalid_i` pulse with `busy_o`=0: required no `mgr_rvalid_o`, and `proto_err_o`=1 from the next cycle until reset.
- **Reset mid-operation.** Assert `rst_i` with 2 transactions outstanding. Required: all outputs 0 immediately (asynchronous), and a first request after release is granted to manager 0.
